// File: rtl/param_sync_fifo_pkg.sv
// Shared width helpers for the synchronous FIFO family.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package param_sync_fifo_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of a fill counter that must represent 0..depth inclusive.
  function automatic int cw_f(input int depth);
    return clog2(depth + 1);
  endfunction

  // Width of a pointer addressing 0..depth-1; never narrower than one bit.
  function automatic int aw_f(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one read port.
// Latency: write visible next cycle; read registered on re_i, or combinational head when FWFT.
// Backpressure: none here; the controller only issues legal reads and writes.
module param_sync_fifo_ram
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int FWFT  = 0,
  localparam int AW   = aw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic             show_head_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array is deliberately not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Capture the word being popped; holds otherwise so dout is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  // Fall-through mode shows the live head while one exists, else the last popped word.
  assign rdata_o = ((FWFT != 0) && show_head_i) ? mem_q[raddr_i] : rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth, with fill level, programmable thresholds and sticky errors.
// Latency: write -> not-empty one cycle; read data one cycle after rd_en (or head shown when FWFT).
// Backpressure: writes refused when full unless paired with an accepted read; rd_en ignored when empty.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 64,
  parameter int PROG_FULL  = 56,
  parameter int PROG_EMPTY = 4,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     prog_full,
  output logic                     prog_empty,
  output logic [cw_f(DEPTH)-1:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = cw_f(DEPTH);
  localparam int AW = aw_f(DEPTH);

  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PF_CNT    = CW'(PROG_FULL);
  localparam logic [CW-1:0] PE_CNT    = CW'(PROG_EMPTY);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          pfull_q,  pfull_d;
  logic          pempty_q, pempty_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          rd_acc;
  logic          wr_acc;

  // Explicit wrap so non-power-of-two depths use every entry.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign rd_acc = rd_en & ~empty_q;
  assign wr_acc = wr_en & (~full_q | rd_acc);

  // Next pointers, level and flags; flags come from the next level so they track count exactly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (wr_en & ~wr_acc);
      udf_d = udf_q | (rd_en & empty_q);
    end
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    pfull_d  = (count_d >= PF_CNT);
    pempty_d = (count_d <= PE_CNT);
  end

  // Control and flag state; reset leaves the FIFO empty with errors cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      pfull_q  <= 1'b0;
      pempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      pfull_q  <= pfull_d;
      pempty_q <= pempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Flush suppresses the RAM access so dout keeps its last value.
  param_sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT)
  ) u_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (wr_acc & ~clr),
    .waddr_i     (wr_ptr_q),
    .wdata_i     (din),
    .re_i        (rd_acc & ~clr),
    .raddr_i     (rd_ptr_q),
    .show_head_i (~empty_q),
    .rdata_o     (dout)
  );

  assign full       = full_q;
  assign empty      = empty_q;
  assign prog_full  = pfull_q;
  assign prog_empty = pempty_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for both read modes of the synchronous FIFO (depth 8, thresholds 6/1).
// Latency: expected words are queued on accepted writes and compared when popped.
// Backpressure: acceptance is predicted from the bench's own occupancy model.
module tb_param_sync_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;

  logic         s_clr = 0, s_wr = 0, s_rd = 0;
  logic [W-1:0] s_din = '0, s_dout;
  logic         s_full, s_empty, s_pfull, s_pempty, s_ovf, s_udf;
  logic [3:0]   s_count;

  logic         f_clr = 0, f_wr = 0, f_rd = 0;
  logic [W-1:0] f_din = '0, f_dout;
  logic         f_full, f_empty, f_pfull, f_pempty, f_ovf, f_udf;
  logic [3:0]   f_count;

  int           checks = 0;
  int           errors = 0;
  bit           sel = 0;
  logic [W-1:0] q[$];
  int           mcnt = 0;
  bit           m_ovf = 0, m_udf = 0;
  logic [W-1:0] exp_dout = '0;
  int           max_cnt;

  always #5 clk = ~clk;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .PROG_FULL(6), .PROG_EMPTY(1), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
    .dout(s_dout), .full(s_full), .empty(s_empty), .prog_full(s_pfull), .prog_empty(s_pempty),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf));

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .PROG_FULL(6), .PROG_EMPTY(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .dout(f_dout), .full(f_full), .empty(f_empty), .prog_full(f_pfull), .prog_empty(f_pempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the selected instance against the occupancy model.
  task automatic check_all(input string ph);
    logic [3:0] o_cnt;
    logic o_full, o_empty, o_pf, o_pe, o_ovf, o_udf;
    o_cnt   = sel ? f_count  : s_count;
    o_full  = sel ? f_full   : s_full;
    o_empty = sel ? f_empty  : s_empty;
    o_pf    = sel ? f_pfull  : s_pfull;
    o_pe    = sel ? f_pempty : s_pempty;
    o_ovf   = sel ? f_ovf    : s_ovf;
    o_udf   = sel ? f_udf    : s_udf;
    chk({ph, ":count"},      32'(o_cnt),   32'(mcnt));
    chk({ph, ":full"},       32'(o_full),  32'(mcnt == D));
    chk({ph, ":empty"},      32'(o_empty), 32'(mcnt == 0));
    chk({ph, ":prog_full"},  32'(o_pf),    32'(mcnt >= 6));
    chk({ph, ":prog_empty"}, 32'(o_pe),    32'(mcnt <= 1));
    chk({ph, ":overflow"},   32'(o_ovf),   32'(m_ovf));
    chk({ph, ":underflow"},  32'(o_udf),   32'(m_udf));
    if (!sel)          chk({ph, ":dout"}, 32'(s_dout), 32'(exp_dout));
    else if (mcnt > 0) chk({ph, ":head"}, 32'(f_dout), 32'(q[0]));
  endtask

  // One clock of stimulus on the selected instance, then model update and checks.
  task automatic step(input string ph, input bit wr, input bit rd, input logic [W-1:0] d,
                      input bit cl);
    bit racc, wacc;
    if (!sel) begin s_wr = wr; s_rd = rd; s_din = d; s_clr = cl; end
    else      begin f_wr = wr; f_rd = rd; f_din = d; f_clr = cl; end
    @(posedge clk);
    if (cl) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      racc = rd && (mcnt > 0);
      wacc = wr && ((mcnt < D) || racc);
      if (wr && !wacc) m_ovf = 1;
      if (rd && mcnt == 0) m_udf = 1;
      if (racc) exp_dout = q.pop_front();
      if (wacc) q.push_back(d);
    end
    mcnt = q.size();
    #1;
    s_wr = 0; s_rd = 0; s_clr = 0;
    f_wr = 0; f_rd = 0; f_clr = 0;
    check_all(ph);
  endtask

  // Asynchronous reset asserted away from any edge; outputs must clear without a clock.
  task automatic do_reset(input string ph);
    bit save;
    rst_n = 1'b0;
    #2;
    q.delete();
    mcnt = 0; m_ovf = 0; m_udf = 0; exp_dout = '0;
    save = sel;
    sel = 0; check_all({ph, ":std"});
    sel = 1; check_all({ph, ":fwft"});
    chk({ph, ":fwft_dout"}, 32'(f_dout), 32'h0);
    sel = save;
    s_wr = 0; s_din = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    // Fill, then one refused write.
    sel = 0;
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, W'(i), 0);
    step("ovf", 1, 0, 8'hFF, 0);

    // Drain in order, then one read on empty.
    for (int i = 0; i < 8; i++) step("drain", 0, 1, '0, 0);
    step("udf", 0, 1, '0, 0);

    // Flush with requests present: they are ignored and errors cleared.
    step("clr", 1, 1, 8'h77, 1);

    // Bursts that walk both pointers round the ring many times.
    max_cnt = 0;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 5; i++) begin
        step("wrap_w", 1, 0, W'($urandom_range(0, 255)), 0);
        if (int'(s_count) > max_cnt) max_cnt = int'(s_count);
      end
      for (int i = 0; i < 5; i++) step("wrap_r", 0, 1, '0, 0);
    end
    chk("wrap_max_count", 32'(max_cnt), 32'd5);

    // Full plus simultaneous read/write: both accepted, order kept.
    for (int i = 0; i < 8; i++) step("sfill", 1, 0, W'(8'h10 + i), 0);
    for (int i = 0; i < 3; i++) step("simul_full", 1, 1, W'(8'hC0 + i), 0);
    for (int i = 0; i < 8; i++) step("sdrain", 0, 1, '0, 0);

    // Empty plus simultaneous read/write: write taken, read refused.
    step("simul_empty", 1, 1, 8'h42, 0);
    step("simul_pop", 0, 1, '0, 0);
    step("clr2", 0, 0, '0, 1);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, W'(8'h30 + i), 0);
    s_wr = 1; s_din = 8'h55;
    do_reset("rst_mid");
    step("post_rst", 1, 0, 8'h99, 0);
    step("post_rst_rd", 0, 1, '0, 0);

    // Fall-through instance.
    sel = 1;
    step("f_udf", 0, 1, '0, 0);
    step("f_wr_a5", 1, 0, 8'hA5, 0);
    step("f_hold", 0, 0, '0, 0);
    step("f_wr", 1, 0, 8'h3C, 0);
    step("f_wr", 1, 0, 8'h7E, 0);
    step("f_pop", 0, 1, '0, 0);
    for (int i = 0; i < 8; i++) step("f_fill", 1, 0, W'(8'hE0 + i), 0);
    step("f_clr", 1, 0, 8'h11, 1);
    step("f_after", 1, 0, 8'h5A, 0);
    step("f_after_pop", 0, 1, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
